// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file write-port controller.
package regfile_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefNumRegs   = 32;
  localparam int unsigned DefNumReq    = 3;
  localparam int unsigned ZeroRegIdx   = 0;

  typedef enum logic {
    CLEAR,
    RUN
  } wb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts one past the pointer and wraps.
module rr_arbiter #(
  parameter  int unsigned NumReq = 3,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  input  logic              en,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    if (en) begin
      for (int unsigned i = 1; i <= NumReq; i++) begin
        cand = IdxW'((32'(ptr) + i) % NumReq);
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          idx         = cand;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: clears registers after reset, then
// arbitrates writeback requesters round-robin onto one registered write port.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter  int unsigned DataWidth  = DefDataWidth,
  parameter  int unsigned NumRegs    = DefNumRegs,
  parameter  int unsigned IndexWidth = $clog2(NumRegs),
  parameter  int unsigned NumReq     = DefNumReq,
  localparam int unsigned GrantW     = $clog2(NumReq)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NumReq-1:0]                    req_valid,
  input  logic [NumReq-1:0][IndexWidth-1:0]    req_addr,
  input  logic [NumReq-1:0][DataWidth-1:0]     req_data,
  output logic [NumReq-1:0]                    req_ready,
  output logic                                 writeEn,
  output logic [IndexWidth-1:0]                writeAddr,
  output logic [DataWidth-1:0]                 writeData,
  output logic                                 init_done,
  output logic [GrantW-1:0]                    grant_id
);

  // One extra bit so the sweep counter can reach NumRegs as its end marker.
  localparam int unsigned CntW = IndexWidth + 1;

  wb_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [GrantW-1:0]     ptr_q, ptr_d;
  logic                  we_d;
  logic [IndexWidth-1:0] waddr_d;
  logic [DataWidth-1:0]  wdata_d;
  logic [GrantW-1:0]     gid_d;
  logic                  done_d;
  logic [NumReq-1:0]     grant;
  logic [GrantW-1:0]     gidx;
  logic                  arb_en;
  logic                  handshake;

  assign arb_en    = (state_q == RUN);
  assign req_ready = grant;
  assign handshake = |(req_valid & grant);

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx)
  );

  // Next-state and write-port selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = writeAddr;
    wdata_d = writeData;
    gid_d   = grant_id;
    done_d  = init_done;
    case (state_q)
      CLEAR: begin
        if (cnt_q == CntW'(NumRegs)) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          we_d    = 1'b1;
          waddr_d = cnt_q[IndexWidth-1:0];
          wdata_d = '0;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      RUN: begin
        if (handshake) begin
          ptr_d   = gidx;
          gid_d   = gidx;
          waddr_d = req_addr[gidx];
          wdata_d = req_data[gidx];
          // Writes to the hard-wired zero register are accepted but dropped.
          we_d    = (req_addr[gidx] != IndexWidth'(ZeroRegIdx));
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLEAR;
      cnt_q     <= CntW'(1);
      ptr_q     <= GrantW'(NumReq - 1);
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
      grant_id  <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      writeEn   <= we_d;
      writeAddr <= waddr_d;
      writeData <= wdata_d;
      grant_id  <= gid_d;
      init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed grants push expected writes,
// a negedge monitor pops and compares every write seen on the port.
module tb_regfile_wb_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    gid;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0]          req_ready;
  logic                   writeEn;
  logic [AW-1:0]          writeAddr;
  logic [DW-1:0]          writeData;
  logic                   init_done;
  logic [1:0]             grant_id;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] rf [32];
  bit          rf_seeded = 1'b0;

  regfile_wb_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .init_done (init_done),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the write port; seeded with junk so clearing is visible.
  always @(posedge clk) begin
    if (!rf_seeded) begin
      for (int i = 1; i < 32; i++) rf[i] <= 64'hDEAD_0000_0000_0000 | 64'(i);
      rf[0]     <= '0;
      rf_seeded <= 1'b1;
    end else if (writeEn === 1'b1) begin
      rf[writeAddr] <= writeData;
    end
  end

  // Monitor: every write on the port must match the oldest expected entry.
  always @(negedge clk) begin
    if (writeEn === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h gid=%0d, required no write",
                 writeAddr, writeData, grant_id);
      end else begin
        e = exp_q.pop_front();
        if (writeAddr !== e.addr || writeData !== e.data || grant_id !== e.gid) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h gid=%0d, required addr=%0d data=%h gid=%0d",
                   writeAddr, writeData, grant_id, e.addr, e.data, e.gid);
        end
      end
    end
  end

  // One cycle: check ready/init_done at negedge, log expected write, move to next cycle start.
  task automatic step(input logic [NR-1:0] exp_ready, input logic exp_done, input bit do_push);
    exp_t e;
    @(negedge clk);
    checks++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL req_ready @%0t: got %b, required %b", $time, req_ready, exp_ready);
    end
    checks++;
    if (init_done !== exp_done) begin
      errors++;
      $display("FAIL init_done @%0t: got %b, required %b", $time, init_done, exp_done);
    end
    if (do_push && exp_ready != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (exp_ready[i] && req_addr[i] != '0) begin
          e.addr = req_addr[i];
          e.data = req_data[i];
          e.gid  = 2'(i);
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Called at the start of the cycle before the first edge with rst=1 (cycle 0);
  // returns at the start of cycle n.
  task automatic sweep(input int n);
    exp_t e;
    rst = 1'b1;
    for (int k = 1; k <= n; k++) begin
      e.addr = AW'(k);
      e.data = '0;
      e.gid  = '0;
      exp_q.push_back(e);
    end
    for (int c = 0; c < n; c++) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NR-1:0] vec5 [6];
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step('0, 1'b0, 1'b0);

    // Sweep with all requesters already asserting: no ready until cycle 32.
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    sweep(31);
    step('0, 1'b0, 1'b0);                  // cycle 31
    for (int i = 0; i < 32; i++) chk64($sformatf("clear_rf%0d", i), rf[i], '0);

    // All three valid continuously: grants 0,1,2,0,1,2 from cycle 32.
    step(3'b001, 1'b1, 1'b1);
    step(3'b010, 1'b1, 1'b1);
    step(3'b100, 1'b1, 1'b1);
    step(3'b001, 1'b1, 1'b1);
    step(3'b010, 1'b1, 1'b1);
    step(3'b100, 1'b1, 1'b1);
    req_valid = '0;
    step('0, 1'b1, 1'b0);
    chk64("rf5", rf[5], 64'hAAAA_0000_0000_0001);
    chk64("rf6", rf[6], 64'hBBBB_0000_0000_0002);
    chk64("rf7", rf[7], 64'hCCCC_0000_0000_0003);

    // Requester 1 alone writes all ones to register 31.
    req_valid   = 3'b010;
    req_addr[1] = 5'd31;
    req_data[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    step(3'b010, 1'b1, 1'b1);
    req_valid = '0;
    step('0, 1'b1, 1'b0);
    chk64("rf31_ones", rf[31], 64'hFFFF_FFFF_FFFF_FFFF);

    // Requester 0 to register 0: accepted, write dropped.
    req_valid   = 3'b001;
    req_addr[0] = 5'd0;
    req_data[0] = 64'h1234_5678_9ABC_DEF0;
    step(3'b001, 1'b1, 1'b1);
    req_valid = '0;
    step('0, 1'b1, 1'b0);
    chk64("rf0_zero", rf[0], '0);

    // Requester 2 held, 0 and 1 toggling together; pointer starts at 0.
    req_addr = {5'd12, 5'd11, 5'd10};
    req_data = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0F0F_0F0F_0F0F_0F0F};
    vec5[0] = 3'b010; vec5[1] = 3'b100; vec5[2] = 3'b001;
    vec5[3] = 3'b100; vec5[4] = 3'b001; vec5[5] = 3'b100;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c % 2 == 0) ? 3'b111 : 3'b100;
      step(vec5[c], 1'b1, 1'b1);
    end
    req_valid = '0;
    step('0, 1'b1, 1'b0);

    // Reset from RUN, then reset again at sweep cycle 10.
    rst = 1'b0;
    step('0, 1'b1, 1'b0);
    sweep(10);
    rst = 1'b0;
    step('0, 1'b0, 1'b0);                  // cycle 10 still shows register 10
    sweep(31);
    step('0, 1'b0, 1'b0);

    // Grant at cycle 32, then reset while a second grant is pending.
    req_valid   = 3'b100;
    req_addr[2] = 5'd20;
    req_data[2] = 64'h5555_AAAA_5555_AAAA;
    step(3'b100, 1'b1, 1'b1);
    rst = 1'b0;
    step(3'b100, 1'b1, 1'b0);              // handshake at reset edge is discarded
    req_valid = '0;
    sweep(31);
    step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) chk64($sformatf("reclear_rf%0d", i), rf[i], '0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
